// File: rtl/store_narrow_unit.sv
// rtl/store_narrow_unit.sv - MEM-stage store narrower with lane placement and req/ack memory write
//
// Purpose: narrows a 32-bit store value to byte/half/word, places it on the
// memory byte lanes with byte enables, and performs a request/acknowledge
// write to data memory, stalling the pipeline while the write is outstanding.
//
// Optional feature macro: STORE_MISALIGN_TRAP_EN (trap misaligned half/word
// stores instead of silently masking the low address bits).
//
// Parameters:
//   BIG_ENDIAN   1 = byte offset k on lane 3-k, 0 = offset k on lane k
//   ACK_TIMEOUT  REQ cycles without memAck before abort (1..65535)
//
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   storeValid/storeReady       store handshake from the MEM stage
//   storeSize                   00 byte, 01 half, 10 word, 11 reserved
//   address, writeData          store byte address and rt value
//   memAddr/memWdata/memByteEn  registered word address, lane data, enables
//   memReq/memAck               data-memory write handshake
//   stall                       high whenever a write is outstanding
//   storeDone/busError          one-cycle completion / error pulses
//   misalignFault               one-cycle misaligned-store trap pulse
module store_narrow_unit #(
  parameter int BIG_ENDIAN  = 1,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        storeValid,
  output logic        storeReady,
  input  logic [1:0]  storeSize,
  input  logic [31:0] address,
  input  logic [31:0] writeData,
  output logic [31:0] memAddr,
  output logic [31:0] memWdata,
  output logic [3:0]  memByteEn,
  output logic        memReq,
  input  logic        memAck,
  output logic        stall,
  output logic        storeDone,
  output logic        busError,
  output logic        misalignFault
);

  typedef enum logic {IDLE, REQ} state_t;

  // Timeout fires on the REQ cycle whose count is ACK_TIMEOUT-1, so the
  // request is held for exactly ACK_TIMEOUT cycles.
  localparam logic [15:0] TO_LAST = 16'(ACK_TIMEOUT - 1);

  state_t      state;
  logic [15:0] cnt;

  logic [1:0]  byte_lane;
  logic [31:0] wdata_n;
  logic [3:0]  be_n;
  logic        trap_hit;

  assign storeReady = (state == IDLE);
  assign stall      = (state != IDLE);

  // 3-k on two bits is simply the bitwise complement of k.
  assign byte_lane = (BIG_ENDIAN != 0) ? ~address[1:0] : address[1:0];

  always_comb begin
    wdata_n = writeData;
    be_n    = 4'b1111;
    case (storeSize)
      2'b00: begin
        wdata_n = {4{writeData[7:0]}};
        be_n    = 4'b0001 << byte_lane;
      end
      2'b01: begin
        wdata_n = {2{writeData[15:0]}};
        // Only address[1] selects the halfword; address[0] is masked.
        if ((BIG_ENDIAN != 0) ? !address[1] : address[1])
          be_n = 4'b1100;
        else
          be_n = 4'b0011;
      end
      default: begin
        wdata_n = writeData;
        be_n    = 4'b1111;
      end
    endcase
  end

`ifdef STORE_MISALIGN_TRAP_EN
  assign trap_hit = ((storeSize == 2'b01) && address[0]) ||
                    ((storeSize == 2'b10) && (address[1:0] != 2'b00));

  always_ff @(posedge clk) begin
    if (!rst_n)
      misalignFault <= 1'b0;
    else
      misalignFault <= (state == IDLE) && storeValid && trap_hit;
  end
`else
  assign trap_hit      = 1'b0;
  assign misalignFault = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= 16'd0;
      memAddr   <= 32'd0;
      memWdata  <= 32'd0;
      memByteEn <= 4'd0;
      memReq    <= 1'b0;
      storeDone <= 1'b0;
      busError  <= 1'b0;
    end else begin
      storeDone <= 1'b0;
      busError  <= 1'b0;
      case (state)
        IDLE: begin
          if (storeValid) begin
            if (storeSize == 2'b11) begin
              busError <= 1'b1;
            end else if (!trap_hit) begin
              memAddr   <= {address[31:2], 2'b00};
              memWdata  <= wdata_n;
              memByteEn <= be_n;
              memReq    <= 1'b1;
              cnt       <= 16'd0;
              state     <= REQ;
            end
          end
        end
        REQ: begin
          // Ack has priority over a timeout landing in the same cycle.
          if (memAck) begin
            memReq    <= 1'b0;
            storeDone <= 1'b1;
            cnt       <= 16'd0;
            state     <= IDLE;
          end else if (cnt == TO_LAST) begin
            memReq   <= 1'b0;
            busError <= 1'b1;
            cnt      <= 16'd0;
            state    <= IDLE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/store_narrow_unit.md
# store_narrow_unit

Store-path data narrower for the MIPS MEM stage, the write-side counterpart of the immediate/load sign-extension path: it takes a 32-bit register value and narrows it to byte, halfword or word, places it on the correct byte lanes with byte enables, and drives a request/acknowledge write to data memory. It sits between the EX/MEM pipeline register and the data-memory port and stalls the pipeline while a write is outstanding.

## Interface
Parameters:
- `BIG_ENDIAN`, 1: lane mapping; 1 = byte offset k on lane 3-k, 0 = offset k on lane k.
- `ACK_TIMEOUT`, 255: cycles in REQ without `memAck` before abort; legal range 1..65535.

Ports:
- `clk`  in  1  single clock, all logic on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `storeValid`  in  1  MEM stage presents a store.
- `storeReady`  out  1  unit can accept a store this cycle.
- `storeSize`  in  2  00 byte, 01 half, 10 word, 11 reserved.
- `address`  in  32  byte address of the store.
- `writeData`  in  32  rt register value; low bits used for narrow sizes.
- `memAddr`  out  32  word address, `{addr[31:2],2'b00}`.
- `memWdata`  out  32  lane-placed data; lane i = bits [8i+7:8i].
- `memByteEn`  out  4  one bit per lane.
- `memReq`  out  1  write request, held until ack or timeout.
- `memAck`  in  1  memory accepted the write.
- `stall`  out  1  high whenever state is not IDLE.
- `storeDone`  out  1  one-cycle pulse, write completed.
- `busError`  out  1  one-cycle pulse, timeout or reserved size.
- `misalignFault`  out  1  one-cycle pulse, misaligned store trapped (see Configuration).

## Operation
- States: IDLE, REQ.
- IDLE: `storeReady`=1, `memReq`=0. Accept on `storeValid & storeReady`; latch address/size/data; compute lanes; next cycle enter REQ.
- Data placement: byte -> `{4{writeData[7:0]}}`; half -> `{2{writeData[15:0]}}`; word -> `writeData`. Upper bits of `writeData` ignored for narrow sizes; no overflow check.
- Byte enable: byte = one-hot on lane of offset `address[1:0]`; half = two lanes of offset `{address[1],0}` (BIG_ENDIAN=1: offset 0 -> 4'b1100, offset 2 -> 4'b0011; BIG_ENDIAN=0 reversed); word = 4'b1111.
- REQ: `memReq`=1; `memAddr`, `memWdata`, `memByteEn` held stable until leaving. Timeout counter increments each REQ cycle without ack.
- `memAck` in REQ -> IDLE next cycle, `storeDone`=1 in that cycle.
- Counter reaches `ACK_TIMEOUT` without ack -> IDLE, `busError` pulse, no `storeDone`.
- Ack and timeout in same cycle: ack wins.
- `memAck` while in IDLE: ignored.
- Reserved size 11: accepted, no REQ, stays IDLE, `busError` pulse next cycle.
- Reset mid-REQ: request dropped immediately at the reset edge; no `storeDone`/`busError`.

## Timing
- Reset values: `storeReady`=1, `stall`=0, `memReq`=0, `memAddr`=0, `memWdata`=0, `memByteEn`=0, `storeDone`=0, `busError`=0, `misalignFault`=0, counter=0, state IDLE.
- All outputs registered except `storeReady`/`stall` (decoded from state register).
- Accept cycle T -> `memReq` high T+1. Ack sampled at cycle A -> `storeDone` high A+1, `storeReady` high A+1, new store acceptable A+1.
- Minimum throughput: one store per 2 cycles (zero-wait ack).
- Timeout: with no ack, `busError` high at T+1+`ACK_TIMEOUT`.

## Configuration
- `STORE_MISALIGN_TRAP_EN` defined: half with `address[0]`=1, or word with `address[1:0]`!=0, is accepted, no REQ, `misalignFault` pulses next cycle, state stays IDLE.
- Not defined: no trap; low address bits silently masked (half uses `{address[1],0}`, word uses offset 0) and write proceeds normally; `misalignFault` tied 0.

## Test plan
- Byte, BIG_ENDIAN=1, address 0x1003, writeData 0xDEADBEEF, ack at first REQ cycle -> `memAddr`=0x1000, `memWdata`=0xEFEFEFEF, `memByteEn`=4'b0001, `storeDone` 2 cycles after accept.
- Half, address 0x2002, writeData 0x12345678, ack after 3 wait cycles -> `memWdata`=0x56785678, `memByteEn`=4'b0011, outputs stable all 4 REQ cycles, `stall` high throughout.
- Word, address 0x3000, writeData 0xCAFEF00D, no ack, ACK_TIMEOUT=4 -> `busError` pulse 5 cycles after accept, no `storeDone`, `storeReady`=1 next cycle.
- Half at 0x4001 with `STORE_MISALIGN_TRAP_EN` -> no `memReq`, `misalignFault` pulse; without macro -> `memByteEn`=4'b1100, write completes.
- `rst_n`=0 while in REQ -> next cycle all outputs at reset values; late `memAck` ignored, no `storeDone`.
- storeSize 11 -> no `memReq`, `busError` one-cycle pulse, back-to-back store accepted following cycle.
